// File: rtl/apb_master_bridge.sv
// APB4 initiator: one valid/ready request becomes one SETUP/ACCESS transfer; define APB_TIMEOUT_EN to abort long ACCESS phases.
// Latency: 3 cycles from accept to rsp_valid_o, plus wait states; req_ready_o stays low until the response is consumed.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                    clk_i,
    input  logic                    arst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_write_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_strb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_slverr_o,
    output logic                    rsp_timeout_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic                    pready_i,
    input  logic                    pslverr_i,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    output logic                    busy_o
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state;
    state_t state_nxt;
    logic   abort;

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    // Counter is cleared during SETUP so it starts at zero on ACCESS entry.
    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            to_cnt <= '0;
        end else if (state == SETUP) begin
            to_cnt <= '0;
        end else if (state == ACCESS && !pready_i) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign abort = (state == ACCESS) && !pready_i && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            rsp_timeout_o <= 1'b0;
        end else if (state == ACCESS && pready_i) begin
            rsp_timeout_o <= 1'b0;
        end else if (abort) begin
            rsp_timeout_o <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign abort              = 1'b0;
    assign rsp_timeout_o      = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid_i)         state_nxt = SETUP;
            SETUP:                            state_nxt = ACCESS;
            ACCESS:  if (pready_i || abort)   state_nxt = RESP;
            RESP:    if (rsp_ready_i)         state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state == IDLE);
        busy_o      = (state != IDLE);
        psel_o      = (state == SETUP) || (state == ACCESS);
        penable_o   = (state == ACCESS);
        rsp_valid_o = (state == RESP);
    end

    // Request fields are latched once at accept and held through the whole transfer.
    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            paddr_o  <= '0;
            pwrite_o <= 1'b0;
            pwdata_o <= '0;
            pstrb_o  <= '0;
        end else if (state == IDLE && req_valid_i) begin
            paddr_o  <= req_addr_i;
            pwrite_o <= req_write_i;
            pwdata_o <= req_write_i ? req_wdata_i : '0;
            pstrb_o  <= req_write_i ? req_strb_i : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            rsp_rdata_o  <= '0;
            rsp_slverr_o <= 1'b0;
        end else if (state == ACCESS && pready_i) begin
            rsp_rdata_o  <= pwrite_o ? '0 : prdata_i;
            rsp_slverr_o <= pslverr_i;
        end else if (abort) begin
            rsp_rdata_o  <= '0;
            rsp_slverr_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a vector table of APB transfers plus reset, idle and timeout sequences.
module tb_apb_master_bridge;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_master_bridge #(
        .ADDR_WIDTH     (5),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i         (clk),
        .arst_ni       (arst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_write_i   (req_write),
        .req_wdata_i   (req_wdata),
        .req_strb_i    (req_strb),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_slverr_o  (rsp_slverr),
        .rsp_timeout_o (rsp_timeout),
        .psel_o        (psel),
        .penable_o     (penable),
        .pwrite_o      (pwrite),
        .paddr_o       (paddr),
        .pwdata_o      (pwdata),
        .pstrb_o       (pstrb),
        .pready_i      (pready),
        .pslverr_i     (pslverr),
        .prdata_i      (prdata),
        .busy_o        (busy)
    );

    typedef struct {
        logic        write;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic        slverr;
        logic [31:0] prdata;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_slverr;
        logic        exp_timeout;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Runs one request through the bridge, acting as the APB responder and response consumer.
    task automatic run_txn(input vec_t v);
        int lat;
        int acc;
        logic [31:0] exp_pwdata;
        logic [3:0]  exp_pstrb;
        exp_pwdata = v.write ? v.wdata : 32'h0;
        exp_pstrb  = v.write ? v.strb : 4'h0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_strb  = v.strb;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = 32'h0;
        chk("accept_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 32'hFFFF_FFFF;
        req_addr  = 5'h0;
        req_strb  = 4'hF;
        lat = 1;
        acc = 0;
        chk("setup_psel_penable", {30'h0, psel, penable}, 32'h2);
        chk("setup_paddr", {27'h0, paddr}, {27'h0, v.addr});
        chk("setup_pwrite", {31'h0, pwrite}, {31'h0, v.write});
        chk("setup_pwdata", pwdata, exp_pwdata);
        chk("setup_pstrb", {28'h0, pstrb}, {28'h0, exp_pstrb});
        chk("setup_req_ready", {31'h0, req_ready}, 32'h0);
        forever begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
            if (lat > 20) begin
                chk("rsp_valid_timeout", {31'h0, rsp_valid}, 32'h1);
                break;
            end
            chk("access_psel_penable", {30'h0, psel, penable}, 32'h3);
            chk("access_paddr", {27'h0, paddr}, {27'h0, v.addr});
            chk("access_pwdata", pwdata, exp_pwdata);
            chk("access_pstrb", {28'h0, pstrb}, {28'h0, exp_pstrb});
            pready  = (acc == v.waits);
            pslverr = v.slverr;
            prdata  = v.prdata;
            acc++;
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        chk("rsp_latency", lat, v.exp_lat);
        chk("rsp_psel_dropped", {30'h0, psel, penable}, 32'h0);
        for (int h = 0; h <= v.hold; h++) begin
            chk("rsp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("rsp_rdata", rsp_rdata, v.exp_rdata);
            chk("rsp_slverr", {31'h0, rsp_slverr}, {31'h0, v.exp_slverr});
            chk("rsp_timeout", {31'h0, rsp_timeout}, {31'h0, v.exp_timeout});
            chk("rsp_req_ready", {31'h0, req_ready}, 32'h0);
            if (h == v.hold) rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        chk("post_rsp_idle", {29'h0, req_ready, rsp_valid, busy}, 32'h4);
    endtask

    vec_t vecs[5];

    initial begin
        arst_n    = 1'b0;
        req_valid = 1'b0;
        req_addr  = 5'h0;
        req_write = 1'b0;
        req_wdata = 32'h0;
        req_strb  = 4'h0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = 32'h0;

        //            wr    addr   wdata         strb  wt slv prdata        hold exp_rdata     slv  to  lat
        vecs[0] = '{1'b1, 5'h04, 32'd868,      4'hF, 0, 0, 32'hDEADBEEF, 0, 32'h0,        1'b0, 1'b0, 3};
        vecs[1] = '{1'b0, 5'h18, 32'hCAFEF00D, 4'hF, 2, 0, 32'h00000055, 0, 32'h00000055, 1'b0, 1'b0, 5};
        vecs[2] = '{1'b1, 5'h1F, 32'hA5A5A5A5, 4'h3, 0, 1, 32'h77777777, 0, 32'h0,        1'b1, 1'b0, 3};
        vecs[3] = '{1'b0, 5'h0A, 32'h0,        4'h0, 1, 1, 32'h12345678, 0, 32'h12345678, 1'b1, 1'b0, 4};
        vecs[4] = '{1'b0, 5'h00, 32'h0,        4'h0, 0, 0, 32'hFFFFFFFF, 5, 32'hFFFFFFFF, 1'b0, 1'b0, 3};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
        chk("reset_ctrl", {27'h0, psel, penable, pwrite, rsp_valid, busy}, 32'h0);
        chk("reset_paddr", {27'h0, paddr}, 32'h0);
        chk("reset_pwdata", pwdata, 32'h0);
        chk("reset_pstrb", {28'h0, pstrb}, 32'h0);
        chk("reset_rsp", {30'h0, rsp_slverr, rsp_timeout}, 32'h0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        arst_n = 1'b1;

        // rsp_ready held high while idle must not start anything.
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_rsp_ready", {29'h0, req_ready, rsp_valid, busy}, 32'h4);
        rsp_ready = 1'b0;

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

`ifdef APB_TIMEOUT_EN
        begin
            vec_t tv;
            tv = '{1'b0, 5'h11, 32'h0, 4'h0, 1000, 0, 32'h99999999, 0, 32'h0, 1'b1, 1'b1, 10};
            run_txn(tv);
            run_txn(vecs[0]);
        end
`endif

        // Reset during ACCESS: bus drops on the next edge and no response appears.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 5'h05;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_reset_access", {30'h0, psel, penable}, 32'h3);
        arst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_psel_penable", {30'h0, psel, penable}, 32'h0);
        chk("midreset_req_ready", {31'h0, req_ready}, 32'h1);
        arst_n = 1'b1;
        pready = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("midreset_no_rsp", {30'h0, rsp_valid, busy}, 32'h0);
        end
        pready = 1'b0;
        rsp_ready = 1'b0;

        run_txn(vecs[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
